dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory with fixed MEM_LAT access time.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin grants; default build uses fixed priority (req0).
module dmem_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [7:0]  req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_rsp_valid,
    output logic [63:0] req0_rdata,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [7:0]  req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_rsp_valid,
    output logic [63:0] req1_rdata,
    output logic        mem_read_data_flag,
    output logic        mem_write_data_flag,
    output logic [7:0]  mem_address_of_data,
    output logic [31:0] mem_data_to_write,
    input  logic [63:0] mem_data_read_out
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        winner_q, winner_d;
    logic        write_q, write_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [63:0] rdata0_q, rdata0_d;
    logic [63:0] rdata1_q, rdata1_d;
    logic        grant0, grant1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Requester granted most recently; reset value 1 gives req0 priority first.
    logic last_q, last_d;

    always_comb begin
        grant1 = req1_valid && (!req0_valid || !last_q);
        grant0 = req0_valid && !grant1;
        last_d = last_q;
        if (state_q == StIdle && (grant0 || grant1)) begin
            last_d = grant1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    winner_d = grant1;
                    write_d  = grant1 ? req1_write : req0_write;
                    addr_d   = grant1 ? req1_addr : req0_addr;
                    wdata_d  = grant1 ? req1_wdata : req0_wdata;
                    cnt_d    = 4'(MEM_LAT - 1);
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    if (!write_q) begin
                        if (winner_q) begin
                            rdata1_d = mem_data_read_out;
                        end else begin
                            rdata0_d = mem_data_read_out;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            winner_q <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= 8'd0;
            wdata_q  <= 32'd0;
            rdata0_q <= 64'd0;
            rdata1_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Bus and strobes decode from state only, so reset drops them without waiting for a clock.
    always_comb begin
        req0_ready          = (state_q == StIdle) && grant0;
        req1_ready          = (state_q == StIdle) && grant1;
        req0_rsp_valid      = (state_q == StResp) && !winner_q;
        req1_rsp_valid      = (state_q == StResp) && winner_q;
        mem_read_data_flag  = (state_q == StAccess) && !write_q;
        mem_write_data_flag = (state_q == StAccess) && write_q;
        mem_address_of_data = (state_q == StAccess) ? addr_q : 8'd0;
        mem_data_to_write   = (state_q == StAccess) ? wdata_q : 32'd0;
        req0_rdata          = rdata0_q;
        req1_rdata          = rdata1_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a behavioural 256x64 memory model.
module tb_dmem_arbiter;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_write, req0_ready, req0_rsp_valid;
    logic [7:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic [63:0] req0_rdata;
    logic        req1_valid, req1_write, req1_ready, req1_rsp_valid;
    logic [7:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic [63:0] req1_rdata;
    logic        mem_read_data_flag, mem_write_data_flag;
    logic [7:0]  mem_address_of_data;
    logic [31:0] mem_data_to_write;
    logic [63:0] mem_data_read_out;

    logic [63:0] mem [256];
    logic [63:0] exp_rd0, exp_rd1;
    int          n_checks;
    int          n_fail;

    typedef struct {
        logic        who;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [9];

    dmem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req0_valid          (req0_valid),
        .req0_write          (req0_write),
        .req0_addr           (req0_addr),
        .req0_wdata          (req0_wdata),
        .req0_ready          (req0_ready),
        .req0_rsp_valid      (req0_rsp_valid),
        .req0_rdata          (req0_rdata),
        .req1_valid          (req1_valid),
        .req1_write          (req1_write),
        .req1_addr           (req1_addr),
        .req1_wdata          (req1_wdata),
        .req1_ready          (req1_ready),
        .req1_rsp_valid      (req1_rsp_valid),
        .req1_rdata          (req1_rdata),
        .mem_read_data_flag  (mem_read_data_flag),
        .mem_write_data_flag (mem_write_data_flag),
        .mem_address_of_data (mem_address_of_data),
        .mem_data_to_write   (mem_data_to_write),
        .mem_data_read_out   (mem_data_read_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {24'hABCDEF, 8'(i), 24'h0, 8'(i)};
        end
        mem[5] = 64'd5;
    end

    always @(posedge clk) begin
        if (mem_write_data_flag) begin
            mem[mem_address_of_data] <= {32'h0, mem_data_to_write};
        end
    end

    assign mem_data_read_out = mem[mem_address_of_data];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic who, input logic v, input logic w, input logic [7:0] a,
                         input logic [31:0] d);
        if (who) begin
            req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
        end
    endtask

    // One complete access; the other requester pokes valid mid-access and withdraws it.
    task automatic transact(input logic who, input logic wr, input logic [7:0] a,
                            input logic [31:0] wd, input logic [63:0] exp);
        int waitc, rd_n, wr_n, late, bad, zero_bad, rsp_n, rsp_at, other_rsp;
        logic rdy;
        waitc = 0; rd_n = 0; wr_n = 0; late = 0; bad = 0; zero_bad = 0;
        rsp_n = 0; rsp_at = 0; other_rsp = 0;
        @(negedge clk);
        drive(who, 1'b1, wr, a, wd);
        #1;
        rdy = who ? req1_ready : req0_ready;
        while (!rdy && waitc < 20) begin
            @(negedge clk); #1;
            waitc++;
            rdy = who ? req1_ready : req0_ready;
        end
        chk("ready", rdy, 1'b1);
        chk("other_ready_low", who ? req0_ready : req1_ready, 1'b0);
        if (!rdy) begin
            drive(who, 1'b0, 1'b0, 8'h0, 32'h0);
            return;
        end
        @(posedge clk);
        for (int i = 1; i <= int'(LAT) + 5; i++) begin
            @(negedge clk);
            if (mem_read_data_flag) rd_n++;
            if (mem_write_data_flag) wr_n++;
            if (mem_read_data_flag || mem_write_data_flag) begin
                if (i > int'(LAT)) late++;
                if (mem_address_of_data !== a || (wr && mem_data_to_write !== wd)) bad++;
            end else if (mem_address_of_data !== 8'h0 || mem_data_to_write !== 32'h0) begin
                zero_bad++;
            end
            if (who ? req1_rsp_valid : req0_rsp_valid) begin
                rsp_n++;
                rsp_at = i;
            end
            if (who ? req0_rsp_valid : req1_rsp_valid) other_rsp++;
            if (i == 1) begin
                drive(who, 1'b0, ~wr, ~a, ~wd);
                drive(!who, 1'b1, 1'b1, 8'h33, 32'hBAD0BAD0);
            end
            if (i == 2) drive(!who, 1'b0, 1'b0, 8'h0, 32'h0);
        end
        chk("read_flag_cycles", rd_n, wr ? 0 : LAT);
        chk("write_flag_cycles", wr_n, wr ? LAT : 0);
        chk("late_or_withdrawn_flags", late, 0);
        chk("bus_addr_data", bad, 0);
        chk("bus_zero_outside_access", zero_bad, 0);
        chk("rsp_pulse_count", rsp_n, 1);
        chk("rsp_latency", rsp_at, LAT + 1);
        chk("other_rsp_quiet", other_rsp, 0);
        if (!wr) begin
            if (who) exp_rd1 = exp;
            else exp_rd0 = exp;
        end
        chk("req0_rdata", req0_rdata, exp_rd0);
        chk("req1_rdata", req1_rdata, exp_rd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_rd0 = 64'd0;
        exp_rd1 = 64'd0;
    endtask

    initial begin
        int g [$];
        int both;
        n_checks = 0;
        n_fail   = 0;
        drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h0, 32'h0);

        tbl[0] = '{1'b0, 1'b0, 8'h05, 32'h0,          64'd5};
        tbl[1] = '{1'b1, 1'b1, 8'hFF, 32'd5,          64'h0};
        tbl[2] = '{1'b1, 1'b0, 8'hFF, 32'h0,          64'd5};
        tbl[3] = '{1'b0, 1'b1, 8'h10, 32'h12345678,   64'h0};
        tbl[4] = '{1'b0, 1'b0, 8'h10, 32'h0,          64'h00000000_12345678};
        tbl[5] = '{1'b1, 1'b0, 8'h05, 32'h0,          64'd5};
        tbl[6] = '{1'b1, 1'b0, 8'h20, 32'h0,          64'hABCDEF20_00000020};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 32'hFFFFFFFF,   64'h0};
        tbl[8] = '{1'b1, 1'b0, 8'h00, 32'h0,          64'h00000000_FFFFFFFF};

        reset = 1'b1;
        #12;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_flags", {mem_read_data_flag, mem_write_data_flag}, 2'b00);
        chk("rst_addr", mem_address_of_data, 8'h0);
        chk("rst_wdata", mem_data_to_write, 32'h0);
        chk("rst_rsp", {req0_rsp_valid, req1_rsp_valid}, 2'b00);
        chk("rst_rdata0", req0_rdata, 64'h0);
        chk("rst_rdata1", req1_rdata, 64'h0);
        do_reset();

        for (int k = 0; k < 9; k++) begin
            transact(tbl[k].who, tbl[k].wr, tbl[k].addr, tbl[k].wd, tbl[k].exp);
        end

        // Both requesters hold valid continuously.
        do_reset();
        both = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h05, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 8'h06, 32'h0);
        for (int c = 0; c < 60 && g.size() < 4; c++) begin
            @(negedge clk); #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready) g.push_back(0);
            else if (req1_ready) g.push_back(1);
        end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h0, 32'h0);
        repeat (LAT + 3) @(negedge clk);
        chk("arb_both_ready", both, 0);
        chk("arb_grant_count", g.size(), 4);
        for (int k = 0; k < g.size(); k++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            chk("arb_grant", g[k], k % 2);
`else
            chk("arb_grant", g[k], 0);
`endif
        end

        // Reset during the second ACCESS cycle.
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h05, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        chk("mid_acc1_rflag", mem_read_data_flag, 1'b1);
        @(negedge clk);
        chk("mid_acc2_rflag", mem_read_data_flag, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_flags", {mem_read_data_flag, mem_write_data_flag}, 2'b00);
        chk("mid_rst_addr", mem_address_of_data, 8'h0);
        @(negedge clk);
        reset = 1'b0;
        both = 0;
        repeat (5) begin
            @(negedge clk);
            if (req0_rsp_valid || req1_rsp_valid) both++;
        end
        chk("mid_rst_no_rsp", both, 0);
        chk("mid_rst_rdata0", req0_rdata, 64'h0);
        transact(1'b0, 1'b0, 8'h05, 32'h0, 64'd5);

        for (int a = 0; a < 256; a++) begin
            transact(1'b0, 1'b0, 8'(a), 32'h0, mem[a]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
